// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
// Slave side of the 68000 bus. It generates DTACK with wait states that
// depend on the region, and it forces DTACK after a timeout when a cycle has
// no select. It also holds the scroll, control and sound-latch registers,
// and it runs the 68000 -> Z80 sound-latch NMI handshake.
//
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   m68k_as_n/rw/uds_n/lds_n   68000 bus strobes
//   m68k_a[6:0]                CPU address bits [7:1]
//   m68k_dout[15:0]            CPU write data
//   m68k_rom_cs, mem_cs        ROM select, OR of the memory-like selects
//   *_scroll_*_cs, sound_latch_cs, ctrl_cs   register selects
//   rom_data_valid             SDRAM read data ready (one-cycle pulse)
//   z80_latch_cs, z80_rd_n     Z80 read of the latch at 0xf800
//   m68k_dtack_n               data acknowledge
//   fg/bg_scroll_x/y, flip, invert_ctrl, coin_cnt, sound_latch   registers
//   z80_nmi_n                  low while a latch value is pending
module m68k_bus_responder #(
    parameter int RAM_WAIT    = 1,
    parameter int BUS_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m68k_as_n,
    input  logic        m68k_rw,
    input  logic        m68k_uds_n,
    input  logic        m68k_lds_n,
    input  logic [6:0]  m68k_a,
    input  logic [15:0] m68k_dout,
    input  logic        m68k_rom_cs,
    input  logic        mem_cs,
    input  logic        fg_scroll_x_cs,
    input  logic        fg_scroll_y_cs,
    input  logic        bg_scroll_x_cs,
    input  logic        bg_scroll_y_cs,
    input  logic        sound_latch_cs,
    input  logic        ctrl_cs,
    input  logic        rom_data_valid,
    input  logic        z80_latch_cs,
    input  logic        z80_rd_n,
    output logic        m68k_dtack_n,
    output logic [15:0] fg_scroll_x,
    output logic [15:0] fg_scroll_y,
    output logic [15:0] bg_scroll_x,
    output logic [15:0] bg_scroll_y,
    output logic        flip,
    output logic        invert_ctrl,
    output logic [1:0]  coin_cnt,
    output logic [7:0]  sound_latch,
    output logic        z80_nmi_n
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    typedef enum logic [1:0] {C_NONE, C_MEM, C_REG, C_ROM} cls_t;

    localparam logic [7:0] RAM_WAIT_CNT = 8'(RAM_WAIT);
    localparam logic [7:0] TIMEOUT_CNT  = 8'(BUS_TIMEOUT);

    function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [15:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rom_seen_q, rom_seen_d;
    logic        armed_q, armed_d;
    logic        wr_done_q, wr_done_d;
    logic [5:0]  sel_q, sel_d;
    logic [5:0]  reg_sel;
    logic        wr_en;

    logic [15:0] fgx_q, fgx_d, fgy_q, fgy_d, bgx_q, bgx_d, bgy_q, bgy_d;
    logic        flip_q, flip_d, inv_q, inv_d;
    logic [1:0]  coin_q, coin_d;
    logic [7:0]  latch_q, latch_d;
    logic        pending_q, pending_d, nmi_n_q, nmi_n_d;
    logic        z80_rd_q, z80_rd_d, z80_rd_prev_q, z80_rd_prev_d;
    logic        z80_rd_pulse, latch_wr;
    logic [15:0] lane_mask;

    // Bit order: fgx, fgy, bgx, bgy, latch, ctrl (bit 0 .. bit 5)
    assign reg_sel = {ctrl_cs, sound_latch_cs, bg_scroll_y_cs, bg_scroll_x_cs,
                      fg_scroll_y_cs, fg_scroll_x_cs};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cls_q      <= C_NONE;
            cnt_q      <= '0;
            rom_seen_q <= 1'b0;
            armed_q    <= 1'b0;
            wr_done_q  <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            cnt_q      <= cnt_d;
            rom_seen_q <= rom_seen_d;
            armed_q    <= armed_d;
            wr_done_q  <= wr_done_d;
            sel_q      <= sel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cnt_d      = cnt_q;
        rom_seen_d = rom_seen_q;
        wr_done_d  = wr_done_q;
        sel_d      = sel_q;
        // A cycle can only start once AS has been seen high since reset, so
        // a cycle that was cut by reset is never acknowledged.
        armed_d    = armed_q | m68k_as_n;
        case (state_q)
            S_IDLE: begin
                wr_done_d  = 1'b0;
                rom_seen_d = 1'b0;
                if (!m68k_as_n && armed_q) begin
                    state_d    = S_WAIT;
                    sel_d      = reg_sel;
                    // ROM data can arrive in the very first cycle
                    rom_seen_d = rom_data_valid;
                    if (m68k_rom_cs) begin
                        cls_d = C_ROM;
                        cnt_d = '0;
                    end else if (|reg_sel) begin
                        cls_d = C_REG;
                        cnt_d = RAM_WAIT_CNT;
                    end else if (mem_cs) begin
                        cls_d = C_MEM;
                        cnt_d = RAM_WAIT_CNT;
                    end else begin
                        cls_d = C_NONE;
                        cnt_d = TIMEOUT_CNT;
                    end
                end
            end
            S_WAIT: begin
                if (m68k_as_n) begin
                    state_d = S_IDLE;
                end else if (cls_q == C_ROM) begin
                    rom_seen_d = rom_seen_q | rom_data_valid;
                    if (rom_seen_q) state_d = S_ACK;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACK: begin
                wr_done_d = 1'b1;
                if (m68k_as_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        m68k_dtack_n = 1'b1;
        wr_en        = 1'b0;
        if (state_q == S_ACK) begin
            m68k_dtack_n = 1'b0;
            wr_en        = !wr_done_q && !m68k_rw && (cls_q == C_REG);
        end
    end

    // Register file and sound-latch handshake
    always_comb begin
        fgx_d         = fgx_q;
        fgy_d         = fgy_q;
        bgx_d         = bgx_q;
        bgy_d         = bgy_q;
        flip_d        = flip_q;
        inv_d         = inv_q;
        coin_d        = coin_q;
        latch_d       = latch_q;
        latch_wr      = 1'b0;
        lane_mask     = {{8{!m68k_uds_n}}, {8{!m68k_lds_n}}};
        z80_rd_d      = z80_latch_cs & !z80_rd_n;
        z80_rd_prev_d = z80_rd_q;
        z80_rd_pulse  = z80_rd_q & !z80_rd_prev_q;
        if (wr_en) begin
            if (sel_q[0]) fgx_d = lane_merge(fgx_q, m68k_dout, lane_mask);
            if (sel_q[1]) fgy_d = lane_merge(fgy_q, m68k_dout, lane_mask);
            if (sel_q[2]) bgx_d = lane_merge(bgx_q, m68k_dout, lane_mask);
            if (sel_q[3]) bgy_d = lane_merge(bgy_q, m68k_dout, lane_mask);
            if (sel_q[4] && !m68k_lds_n) begin
                latch_d  = m68k_dout[7:0];
                latch_wr = 1'b1;
            end
            if (sel_q[5]) begin
                case (m68k_a)
                    7'h23:   inv_d     = |(m68k_dout & lane_mask);
                    7'h28:   coin_d[0] = m68k_dout[0];
                    7'h29:   coin_d[1] = m68k_dout[0];
                    7'h30:   flip_d    = m68k_dout[0];
                    default: ;
                endcase
            end
        end
        // A latch write and a Z80 read in the same cycle: the write wins
        if (latch_wr)          pending_d = 1'b1;
        else if (z80_rd_pulse) pending_d = 1'b0;
        else                   pending_d = pending_q;
        nmi_n_d = !pending_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fgx_q         <= '0;
            fgy_q         <= '0;
            bgx_q         <= '0;
            bgy_q         <= '0;
            flip_q        <= 1'b0;
            inv_q         <= 1'b0;
            coin_q        <= '0;
            latch_q       <= '0;
            pending_q     <= 1'b0;
            nmi_n_q       <= 1'b1;
            z80_rd_q      <= 1'b0;
            z80_rd_prev_q <= 1'b0;
        end else begin
            fgx_q         <= fgx_d;
            fgy_q         <= fgy_d;
            bgx_q         <= bgx_d;
            bgy_q         <= bgy_d;
            flip_q        <= flip_d;
            inv_q         <= inv_d;
            coin_q        <= coin_d;
            latch_q       <= latch_d;
            pending_q     <= pending_d;
            nmi_n_q       <= nmi_n_d;
            z80_rd_q      <= z80_rd_d;
            z80_rd_prev_q <= z80_rd_prev_d;
        end
    end

    assign fg_scroll_x = fgx_q;
    assign fg_scroll_y = fgy_q;
    assign bg_scroll_x = bgx_q;
    assign bg_scroll_y = bgy_q;
    assign flip        = flip_q;
    assign invert_ctrl = inv_q;
    assign coin_cnt    = coin_q;
    assign sound_latch = latch_q;
    assign z80_nmi_n   = nmi_n_q;

endmodule
